// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller definitions: command type, bus widths, timing constants
// and the command-to-pin encoding used by the command arbiter.
package ddr3_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int BA_BITS    = 3;

    localparam int DDR3_TRCD = 6;
    localparam int DDR3_TRAS = 15;
    localparam int DDR3_TRP  = 6;
    localparam int DDR3_TRRD = 4;
    localparam int DDR3_TCCD = 4;
    localparam int DDR3_TWTR = 4;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } ddr3_cmd_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PINS_DESEL = 4'b1111;
    localparam logic [3:0] PINS_NOP   = 4'b0111;

    function automatic logic [3:0] cmd_to_pins(input ddr3_cmd_t cmd);
        logic [3:0] pins;
        case (cmd)
            CMD_ACT: pins = 4'b0011;
            CMD_RD:  pins = 4'b0101;
            CMD_WR:  pins = 4'b0100;
            CMD_PRE: pins = 4'b0010;
            default: pins = PINS_NOP;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// Bank-FSM command request bundle. valid/ready: a bank holds valid, type and addr
// stable until it sees ready high in the same cycle; that cycle is the transfer.
interface ddr3_cmd_arbiter_if #(
    parameter int NUM_BANKS = 4
);
    import ddr3_pkg::*;

    logic [NUM_BANKS-1:0]  bank_cmd_valid;
    ddr3_cmd_t             bank_cmd_type [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_cmd_addr [NUM_BANKS];
    logic [NUM_BANKS-1:0]  bank_cmd_ready;

    modport master (
        output bank_cmd_valid,
        output bank_cmd_type,
        output bank_cmd_addr,
        input  bank_cmd_ready
    );

    modport slave (
        input  bank_cmd_valid,
        input  bank_cmd_type,
        input  bank_cmd_addr,
        output bank_cmd_ready
    );

endinterface

// File: rtl/ddr3_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// N must be a power of two so the index addition wraps on its own.
module ddr3_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Picks one legal bank command per cycle under tRRD/tCCD/tWTR and registers it onto
// the DDR3 pins. Define DDR3_CMD_ARB_SVA_EN to compile in the protocol assertions.
module ddr3_cmd_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int TRRD_CYCLES = DDR3_TRRD,
    parameter int TCCD_CYCLES = DDR3_TCCD,
    parameter int TWTR_CYCLES = DDR3_TWTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ddr3_cmd_arbiter_if.slave     req,
    output logic                  ddr_cs_n,
    output logic                  ddr_ras_n,
    output logic                  ddr_cas_n,
    output logic                  ddr_we_n,
    output logic [BA_BITS-1:0]    ddr_ba,
    output logic [ADDR_WIDTH-1:0] ddr_addr,
    output logic                  issued_valid,
    output logic [BA_BITS-1:0]    issued_bank
);

    localparam int PW = $clog2(NUM_BANKS);
    localparam int CW = 8;

    logic [CW-1:0]         trrd_q, trrd_d, tccd_q, tccd_d, twtr_q, twtr_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]            pins_q, pins_d;
    logic [BA_BITS-1:0]    ba_q, ba_d, issued_bank_q, issued_bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  issued_valid_q, issued_valid_d;

    logic [NUM_BANKS-1:0]  eligible, grant;
    logic [PW-1:0]         win_idx;
    logic                  any_grant;
    ddr3_cmd_t             win_cmd;

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            eligible[i] = 1'b0;
            if (req.bank_cmd_valid[i]) begin
                case (req.bank_cmd_type[i])
                    CMD_ACT: eligible[i] = (trrd_q == '0);
                    CMD_RD:  eligible[i] = (tccd_q == '0) && (twtr_q == '0);
                    CMD_WR:  eligible[i] = (tccd_q == '0);
                    CMD_PRE: eligible[i] = 1'b1;
                    default: eligible[i] = 1'b0;
                endcase
            end
        end
    end

    ddr3_rr_arbiter #(.N(NUM_BANKS)) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign req.bank_cmd_ready = grant;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (grant[i]) win_idx = PW'(i);
        end
        any_grant = |grant;
        win_cmd   = req.bank_cmd_type[win_idx];
    end

    // A load in the grant cycle takes priority over that cycle's decrement.
    always_comb begin
        trrd_d = (trrd_q != '0) ? trrd_q - 1'b1 : '0;
        tccd_d = (tccd_q != '0) ? tccd_q - 1'b1 : '0;
        twtr_d = (twtr_q != '0) ? twtr_q - 1'b1 : '0;
        if (any_grant && win_cmd == CMD_ACT) trrd_d = CW'(TRRD_CYCLES - 1);
        if (any_grant && (win_cmd == CMD_RD || win_cmd == CMD_WR)) tccd_d = CW'(TCCD_CYCLES - 1);
        if (any_grant && win_cmd == CMD_WR) twtr_d = CW'(TWTR_CYCLES - 1);
    end

    always_comb begin
        pins_d         = PINS_NOP;
        ba_d           = ba_q;
        addr_d         = addr_q;
        issued_valid_d = 1'b0;
        issued_bank_d  = issued_bank_q;
        rr_ptr_d       = rr_ptr_q;
        if (any_grant) begin
            pins_d         = cmd_to_pins(win_cmd);
            ba_d           = BA_BITS'(win_idx);
            addr_d         = req.bank_cmd_addr[win_idx];
            issued_valid_d = 1'b1;
            issued_bank_d  = BA_BITS'(win_idx);
            rr_ptr_d       = win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_q         <= PINS_DESEL;
            ba_q           <= '0;
            addr_q         <= '0;
            issued_valid_q <= 1'b0;
            issued_bank_q  <= '0;
            rr_ptr_q       <= '0;
            trrd_q         <= '0;
            tccd_q         <= '0;
            twtr_q         <= '0;
        end else begin
            pins_q         <= pins_d;
            ba_q           <= ba_d;
            addr_q         <= addr_d;
            issued_valid_q <= issued_valid_d;
            issued_bank_q  <= issued_bank_d;
            rr_ptr_q       <= rr_ptr_d;
            trrd_q         <= trrd_d;
            tccd_q         <= tccd_d;
            twtr_q         <= twtr_d;
        end
    end

    assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = pins_q;
    assign ddr_ba       = ba_q;
    assign ddr_addr     = addr_q;
    assign issued_valid = issued_valid_q;
    assign issued_bank  = issued_bank_q;

`ifdef DDR3_CMD_ARB_SVA_EN
    localparam bit SVA_ENABLED = 1'b1;

    logic on_act, on_rw, on_rd, on_wr;
    assign on_act = issued_valid_q && (pins_q == cmd_to_pins(CMD_ACT));
    assign on_rd  = issued_valid_q && (pins_q == cmd_to_pins(CMD_RD));
    assign on_wr  = issued_valid_q && (pins_q == cmd_to_pins(CMD_WR));
    assign on_rw  = on_rd || on_wr;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req.bank_cmd_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req.bank_cmd_ready & ~req.bank_cmd_valid) == '0);
    a_trrd: assert property (@(posedge clk) disable iff (!rst_n)
        on_act |=> !on_act [*TRRD_CYCLES-1]);
    a_tccd: assert property (@(posedge clk) disable iff (!rst_n)
        on_rw |=> !on_rw [*TCCD_CYCLES-1]);
    a_twtr: assert property (@(posedge clk) disable iff (!rst_n)
        on_wr |=> !on_rd [*TWTR_CYCLES-1]);
`else
    localparam bit SVA_ENABLED = 1'b0;
`endif

endmodule
